// File: rtl/alu_rpn_ctrl.sv
// alu_rpn_ctrl: reverse-Polish sequencing controller for a 4-operation M-bit ALU.
// Collects A, B and OpCode from DataIn on successive Enter pulses, evaluates the
// ALU when the opcode is committed, and holds the result and flags for display.
// Optional build macro: ALU_RPN_CHAIN_EN -- Enter in SHOW_RESULT feeds the result
// back as operand A (accumulator chaining) instead of starting over.
module alu_rpn_ctrl #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] DataIn,
  input  logic         Enter,
  input  logic         Undo,
  output logic [M-1:0] ToDisplay,
  output logic [3:0]   Flags,
  output logic [1:0]   CurrentState,
  output logic         ResultValid
);

  typedef enum logic [1:0] {
    WAIT_A      = 2'b00,
    WAIT_B      = 2'b01,
    WAIT_OP     = 2'b10,
    SHOW_RESULT = 2'b11
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [M-1:0]   r_a;
  logic [M-1:0]   r_b;
  logic [1:0]     r_op;
  logic [M-1:0]   r_result;
  logic [3:0]     r_flags;

  logic [1:0]     w_alu_op;
  logic [M:0]     w_add;
  logic [M:0]     w_sub;
  logic [M-1:0]   w_alu_res;
  logic           w_alu_c;
  logic           w_alu_v;
  logic [3:0]     w_alu_flags;

  // While waiting for the opcode the ALU looks at the live switches; otherwise at the committed opcode.
  assign w_alu_op = (r_state == WAIT_OP) ? DataIn[1:0] : r_op;

  // Combinational ALU: add, sub (borrow as carry), OR, AND with {N,Z,C,V} flags.
  always_comb begin
    w_add     = {1'b0, r_a} + {1'b0, r_b};
    w_sub     = {1'b0, r_a} - {1'b0, r_b};
    w_alu_res = {M{1'b0}};
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (w_alu_op)
      2'b00: begin
        w_alu_res = w_add[M-1:0];
        w_alu_c   = w_add[M];
        w_alu_v   = (r_a[M-1] == r_b[M-1]) && (w_add[M-1] != r_a[M-1]);
      end
      2'b01: begin
        w_alu_res = w_sub[M-1:0];
        w_alu_c   = w_sub[M];
        w_alu_v   = (r_a[M-1] != r_b[M-1]) && (w_sub[M-1] != r_a[M-1]);
      end
      2'b10: begin
        w_alu_res = r_a | r_b;
      end
      2'b11: begin
        w_alu_res = r_a & r_b;
      end
      default: begin
        w_alu_res = {M{1'b0}};
      end
    endcase
    w_alu_flags = {w_alu_res[M-1], (w_alu_res == {M{1'b0}}), w_alu_c, w_alu_v};
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: Undo steps back and takes priority over Enter.
  always_comb begin
    w_next_state = r_state;
    if (Undo) begin
      case (r_state)
        WAIT_B:      w_next_state = WAIT_A;
        WAIT_OP:     w_next_state = WAIT_B;
        SHOW_RESULT: w_next_state = WAIT_OP;
        default:     w_next_state = r_state;
      endcase
    end else if (Enter) begin
      case (r_state)
        WAIT_A:      w_next_state = WAIT_B;
        WAIT_B:      w_next_state = WAIT_OP;
        WAIT_OP:     w_next_state = SHOW_RESULT;
`ifdef ALU_RPN_CHAIN_EN
        SHOW_RESULT: w_next_state = WAIT_B;
`else
        SHOW_RESULT: w_next_state = WAIT_A;
`endif
        default:     w_next_state = WAIT_A;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // Field capture and result registers; captured fields survive Undo and are overwritten on the next Enter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= {M{1'b0}};
      r_b      <= {M{1'b0}};
      r_op     <= 2'b00;
      r_result <= {M{1'b0}};
      r_flags  <= 4'b0000;
    end else if (Undo) begin
      if (r_state == SHOW_RESULT) begin
        r_result <= {M{1'b0}};
        r_flags  <= 4'b0000;
      end
    end else if (Enter) begin
      case (r_state)
        WAIT_A:  r_a <= DataIn;
        WAIT_B:  r_b <= DataIn;
        WAIT_OP: begin
          r_op     <= DataIn[1:0];
          r_result <= w_alu_res;
          r_flags  <= w_alu_flags;
        end
        SHOW_RESULT: begin
`ifdef ALU_RPN_CHAIN_EN
          r_a      <= r_result;
          r_b      <= {M{1'b0}};
          r_op     <= 2'b00;
          r_flags  <= 4'b0000;
`else
          r_a      <= {M{1'b0}};
          r_b      <= {M{1'b0}};
          r_op     <= 2'b00;
          r_result <= {M{1'b0}};
          r_flags  <= 4'b0000;
`endif
        end
        default: begin
          r_a <= r_a;
        end
      endcase
    end
  end

  // Output decode from the current state; the display echoes the switches while fields are being entered.
  always_comb begin
    ToDisplay    = {M{1'b0}};
    Flags        = 4'b0000;
    CurrentState = r_state;
    ResultValid  = 1'b0;
    case (r_state)
      WAIT_A:      ToDisplay = DataIn;
      WAIT_B:      ToDisplay = DataIn;
      WAIT_OP:     ToDisplay = {{(M-2){1'b0}}, DataIn[1:0]};
      SHOW_RESULT: begin
        ToDisplay   = r_result;
        Flags       = r_flags;
        ResultValid = 1'b1;
      end
      default:     ToDisplay = {M{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_alu_rpn_ctrl.sv
// Testbench for alu_rpn_ctrl: directed test-plan sequences plus random stimulus,
// checked by a scoreboard against an integer-arithmetic reference model.
module tb_alu_rpn_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] DataIn;
  logic       Enter;
  logic       Undo;
  logic [7:0] ToDisplay;
  logic [3:0] Flags;
  logic [1:0] CurrentState;
  logic       ResultValid;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [7:0] disp;
    logic [3:0] flags;
    logic [1:0] st;
    logic       rv;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: phase 0..3 = waiting for A, B, opcode, showing result.
  int         m_phase;
  logic [7:0] m_a, m_b, m_res;
  logic [1:0] m_op;
  logic [3:0] m_fl;

  alu_rpn_ctrl #(.M(8)) dut (
    .clk(clk), .reset(reset), .DataIn(DataIn), .Enter(Enter), .Undo(Undo),
    .ToDisplay(ToDisplay), .Flags(Flags), .CurrentState(CurrentState),
    .ResultValid(ResultValid)
  );

  always #5 clk = ~clk;

  function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b,
                                  input logic [1:0] op,
                                  output logic [7:0] r, output logic [3:0] f);
    int ua, ub, sa, sb, full, sres;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; full = 0;
    case (op)
      2'd0: begin full = ua + ub; c = (full > 255); sres = sa + sb; v = (sres > 127) || (sres < -128); end
      2'd1: begin full = ua - ub; c = (ua < ub);    sres = sa - sb; v = (sres > 127) || (sres < -128); end
      2'd2: full = ua | ub;
      default: full = ua & ub;
    endcase
    r = 8'(full & 255);
    f = {r[7], (r == 8'h00), c, v};
  endfunction

  function automatic exp_t model_out(input logic [7:0] d);
    exp_t e;
    e.st    = 2'(m_phase);
    e.rv    = (m_phase == 3);
    e.flags = (m_phase == 3) ? m_fl : 4'h0;
    if (m_phase <= 1)      e.disp = d;
    else if (m_phase == 2) e.disp = {6'd0, d[1:0]};
    else                   e.disp = m_res;
    return e;
  endfunction

  task automatic model_step(input logic rst, input logic [7:0] d, input logic en, input logic un);
    if (rst) begin
      m_phase = 0; m_a = 8'h00; m_b = 8'h00; m_op = 2'd0; m_res = 8'h00; m_fl = 4'h0;
    end else if (un) begin
      if (m_phase == 3) begin m_res = 8'h00; m_fl = 4'h0; end
      if (m_phase > 0) m_phase = m_phase - 1;
    end else if (en) begin
      case (m_phase)
        0: begin m_a = d; m_phase = 1; end
        1: begin m_b = d; m_phase = 2; end
        2: begin m_op = d[1:0]; ref_alu(m_a, m_b, m_op, m_res, m_fl); m_phase = 3; end
        default: begin
`ifdef ALU_RPN_CHAIN_EN
          m_a = m_res; m_b = 8'h00; m_op = 2'd0; m_fl = 4'h0; m_phase = 1;
`else
          m_a = 8'h00; m_b = 8'h00; m_op = 2'd0; m_res = 8'h00; m_fl = 4'h0; m_phase = 0;
`endif
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs (called just after a rising edge); queue what the outputs must show mid-cycle.
  task automatic step(input logic rst, input logic [7:0] d, input logic en, input logic un, input bit chk);
    reset = rst; DataIn = d; Enter = en; Undo = un;
    if (chk) sb_q.push_back(model_out(d));
    @(posedge clk);
    model_step(rst, d, en, un);
    #1;
  endtask

  task automatic cmp(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Direct comparison against test-plan constants, taken just after an edge.
  task automatic chk_now(input string name, input logic [7:0] disp, input logic [3:0] fl, input logic [1:0] st);
    #1;
    cmp({name, "_disp"},  int'(ToDisplay),    int'(disp));
    cmp({name, "_flags"}, int'(Flags),        int'(fl));
    cmp({name, "_state"}, int'(CurrentState), int'(st));
  endtask

  // Scoreboard monitor: pops one expectation per cycle and compares on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp("sb_display", int'(ToDisplay),    int'(e.disp));
      cmp("sb_flags",   int'(Flags),        int'(e.flags));
      cmp("sb_state",   int'(CurrentState), int'(e.st));
      cmp("sb_valid",   int'(ResultValid),  int'(e.rv));
    end
  end

  initial begin
    reset = 1'b1; DataIn = 8'h00; Enter = 1'b0; Undo = 1'b0;
    m_phase = 0; m_a = 8'h00; m_b = 8'h00; m_op = 2'd0; m_res = 8'h00; m_fl = 4'h0;
    @(posedge clk); #1;
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);

    // Reset mid-sequence, with Enter also high to show reset wins.
    step(1'b0, 8'h12, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h34, 1'b1, 1'b0, 1'b1);
    chk_now("rst_mid", 8'h34, 4'h0, 2'b00);

    // Add overflow, then Enter in SHOW_RESULT.
    step(1'b0, 8'h7F, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk_now("add_ovf", 8'h80, 4'b1001, 2'b11);
    cmp("add_ovf_valid", int'(ResultValid), 1);
    step(1'b0, 8'hAA, 1'b1, 1'b0, 1'b1);
`ifdef ALU_RPN_CHAIN_EN
    chk_now("after_result", 8'hAA, 4'h0, 2'b01);
`else
    chk_now("after_result", 8'hAA, 4'h0, 2'b00);
`endif

    // Sub to zero, sub with borrow, AND, OR.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h05, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h05, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    chk_now("sub_zero", 8'h00, 4'b0100, 2'b11);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h03, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h05, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    chk_now("sub_borrow", 8'hFE, 4'b1010, 2'b11);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'hF0, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h0F, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h03, 1'b1, 1'b0, 1'b1);
    chk_now("and_zero", 8'h00, 4'b0100, 2'b11);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'hF0, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h0F, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h02, 1'b1, 1'b0, 1'b1);
    chk_now("or_ff", 8'hFF, 4'b1000, 2'b11);

    // Undo priority and stepping back.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h11, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h22, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h03, 1'b1, 1'b1, 1'b1);
    chk_now("undo_prio", 8'h03, 4'h0, 2'b01);
    step(1'b0, 8'h02, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk_now("undo_newb", 8'h13, 4'b0000, 2'b11);
    step(1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
    chk_now("undo_show", 8'h01, 4'h0, 2'b10);
    step(1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    chk_now("undo_resub", 8'h0F, 4'b0000, 2'b11);

    // Chaining sequence.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h10, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h20, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk_now("chain_sum", 8'h30, 4'b0000, 2'b11);
    step(1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
`ifdef ALU_RPN_CHAIN_EN
    step(1'b0, 8'h01, 1'b1, 1'b0, 1'b1); step(1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    chk_now("chain_sub", 8'h2F, 4'b0000, 2'b11);
`else
    chk_now("chain_off", 8'h01, 4'h0, 2'b00);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, e, u;
      logic [7:0] d;
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 2) == 0);
      u = ($urandom_range(0, 7) == 0);
      d = 8'($urandom);
      step(r, d, e, u, 1'b1);
    end

    @(negedge clk);
    cmp("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_rpn_ctrl.md
Name: alu_rpn_ctrl

Overview:
Sequencing controller for the team's 4-operation M-bit ALU (add, sub, OR, AND; 2-bit OpCode; 4-bit Status).
- Collects operand A, operand B and OpCode from one shared data input in reverse-Polish order. Each field is committed by an Enter pulse.
- Holds the ALU result and flags in registers and drives them to the board display/LED wrapper.
- Sits between the debounced switch/button front end and the display driver. Contains one combinational ALU instance.

Parameters:
- M, 8, data width of the operands and the result.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- DataIn  input  M  switch value; source for A, B and OpCode (OpCode = DataIn[1:0])
- Enter  input  1  single-cycle pulse from the debounced button; commits the current field
- Undo  input  1  single-cycle pulse; steps back one field
- ToDisplay  output  M  value shown on the 7-segment display
- Flags  output  4  {N,Z,C,V}: Flags[3]=N, [2]=Z, [1]=C, [0]=V
- CurrentState  output  2  state code for the status LEDs
- ResultValid  output  1  high only in state SHOW_RESULT

Behaviour:
- One clock, clk. Reset is synchronous and active-high. All state and output registers update on the rising edge of clk.
- States and codes: WAIT_A=00, WAIT_B=01, WAIT_OP=10, SHOW_RESULT=11.
- Reset: state=WAIT_A; regA, regB, regOp, regResult and regFlags are all 0; ResultValid=0.
  - Reset overrides Enter and Undo in the same cycle.
  - Reset mid-sequence discards all captured fields.
- Enter transitions:
  - In WAIT_A: regA<=DataIn, go to WAIT_B.
  - In WAIT_B: regB<=DataIn, go to WAIT_OP.
  - In WAIT_OP: regOp<=DataIn[1:0]. On the same edge, regResult and regFlags are loaded from the ALU evaluated with regA, regB and DataIn[1:0]. Go to SHOW_RESULT.
  - In SHOW_RESULT: clear regA, regB, regOp, regResult and regFlags to 0, go to WAIT_A.
- Undo transitions (previously captured registers are kept and overwritten on the next Enter):
  - WAIT_B -> WAIT_A.
  - WAIT_OP -> WAIT_B.
  - SHOW_RESULT -> WAIT_OP; regResult and regFlags are cleared.
  - WAIT_A: no effect.
- Undo and Enter in the same cycle: Undo has priority and Enter is ignored.
- Enter or Undo held high for several cycles acts once per cycle. The front end guarantees single-cycle pulses; this block adds no edge detection.
- Latency: a field is registered on the Enter edge. New state and outputs are visible 1 cycle after the Enter pulse.
- ToDisplay (combinational from state):
  - WAIT_A and WAIT_B: DataIn (live echo).
  - WAIT_OP: zero-extended DataIn[1:0].
  - SHOW_RESULT: regResult.
- Flags: regFlags in SHOW_RESULT, 0 in all other states.
- CurrentState equals the state code. ResultValid = (state==SHOW_RESULT).
- ALU arithmetic, evaluated at M+1 bits:
  - Add: C = bit M of A+B. V = operands have the same sign and the result sign differs.
  - Sub: C = borrow = bit M of {0,A}-{0,B}. V = operands have different signs and the result sign differs from A.
  - OR and AND: C=0, V=0.
  - All operations: N = result[M-1]; Z = (result==0).
- No latches. Every combinational output has a default assignment.

Optional Feature:
- Macro ALU_RPN_CHAIN_EN.
- Defined: Enter in SHOW_RESULT loads regA<=regResult, clears regB, regOp and regFlags, and goes to WAIT_B. This chains accumulator-style operations. Undo behaviour is unchanged.
- Undefined: Enter in SHOW_RESULT clears everything and returns to WAIT_A, as specified above.

Test Plan:
- Reset mid-sequence: A=0x12 entered, reset pulsed -> next cycle CurrentState=00, Flags=0, ToDisplay=DataIn.
- Add overflow: A=0x7F, B=0x01, op=00 -> ToDisplay=0x80, Flags=4'b1001, ResultValid=1 one cycle after the third Enter.
- Sub to zero: A=0x05, B=0x05, op=01 -> 0x00, Flags=4'b0100. Sub with borrow: A=0x03, B=0x05, op=01 -> 0xFE, Flags=4'b1010.
- Logic ops: A=0xF0, B=0x0F, op=11 -> 0x00, Flags=4'b0100. Same operands, op=10 -> 0xFF, Flags=4'b1000.
- Undo and priority:
  - In WAIT_OP, assert Undo together with Enter -> state WAIT_B and regOp unchanged.
  - Then Enter with DataIn=0x02 -> regB=0x02.
  - Undo in SHOW_RESULT -> state WAIT_OP, Flags=0.
- Chain (ALU_RPN_CHAIN_EN defined): 0x10+0x20 -> 0x30. Enter, B=0x01, op=01 -> 0x2F, Flags=4'b0000. With the macro undefined, the same Enter returns to WAIT_A.
